uart_rx_deserializer: RTL and testbench

Serial receive front end of the UART peripheral. It synchronises the RX pin and oversamples it 16× using the programmed baud divisor. It frames 8N1 characters (LSB first) and buffers completed bytes in a small first-word-fall-through FIFO, which the CPU data-register read path drains. Sticky framing and overrun flags feed the status register and the interrupt logic.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_deserializer_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_deserializer.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared framer states and oversampling constants for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// rtl/uart_rx_deserializer_if.sv - CPU-facing receive data/status bundle of the UART receiver
interface uart_rx_deserializer_if #(parameter int DEPTH = 4);

  logic                   pop;
  logic                   clrerr;
  logic [7:0]             dout;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   frameerr;
  logic                   overrun;
  logic                   parityerr;

  modport master (
    output pop, clrerr,
    input  dout, empty, full, count, frameerr, overrun, parityerr
  );

  modport slave (
    input  pop, clrerr,
    output dout, empty, full, count, frameerr, overrun, parityerr
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through byte FIFO holding received characters
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  // A pop frees the slot in the same cycle, so a push at FULL still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW + 1)'(DEPTH));
  assign count = cnt;
  assign dout  = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 16x oversampling 8N1 receive framer with byte FIFO and sticky errors
// Optional even-parity stage is compiled in with RX_PARITY_EN.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic [7:0]             baud,
  input  logic                   rx,
  uart_rx_deserializer_if.slave  bus
);

  rx_state_t  state;
  logic       rx_meta;
  logic       rxs;
  logic [7:0] tcnt;
  logic [3:0] osc;
  logic [2:0] bitidx;
  logic [7:0] shreg;
  logic       bad;
  logic       frameerr;
  logic       overrun;
  logic       tick;
  logic       sample_mid;
  logic       sample_bit;
  logic       push;
  logic       set_fe;
  logic       set_ov;
  logic       fifo_full;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Tick counter idles at the divisor so the first tick after detect is a full period away.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                         tcnt <= '0;
    else if (state == IDLE || !en)     tcnt <= baud;
    else if (tcnt == 8'd0)             tcnt <= baud;
    else                               tcnt <= tcnt - 8'd1;
  end

  assign tick       = (state != IDLE) && (tcnt == 8'd0);
  assign sample_mid = tick && (osc == 4'(MID_SAMPLE - 1));
  assign sample_bit = tick && (osc == 4'(OVERSAMPLE - 1));
  assign set_fe     = en && (state == STOP) && sample_bit && !rxs;
  assign push       = en && (state == STOP) && sample_bit && rxs && !bad;
  assign set_ov     = push && fifo_full && !bus.pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      osc    <= '0;
      bitidx <= '0;
      shreg  <= '0;
      bad    <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          osc   <= '0;
        end
        START: if (tick) begin
          osc <= osc + 4'd1;
          if (sample_mid) begin
            osc    <= '0;
            bitidx <= '0;
            bad    <= 1'b0;
            state  <= rxs ? IDLE : DATA;
          end
        end
        DATA: if (tick) begin
          osc <= osc + 4'd1;
          if (sample_bit) begin
            shreg[bitidx] <= rxs;
            bitidx        <= bitidx + 3'd1;
            if (bitidx == 3'(DATA_BITS - 1))
`ifdef RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
          end
        end
`ifdef RX_PARITY_EN
        PARITY: if (tick) begin
          osc <= osc + 4'd1;
          if (sample_bit) begin
            if (rxs != ^shreg) bad <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: if (tick) begin
          osc <= osc + 4'd1;
          if (sample_bit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as CLRERR wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frameerr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (set_fe)          frameerr <= 1'b1;
      else if (bus.clrerr) frameerr <= 1'b0;
      if (set_ov)          overrun <= 1'b1;
      else if (bus.clrerr) overrun <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  logic parityerr;
  logic set_pe;

  assign set_pe = en && (state == PARITY) && sample_bit && (rxs != ^shreg);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)           parityerr <= 1'b0;
    else if (set_pe)     parityerr <= 1'b1;
    else if (bus.clrerr) parityerr <= 1'b0;
  end

  assign bus.parityerr = parityerr;
`else
  assign bus.parityerr = 1'b0;
`endif

  assign bus.frameerr = frameerr;
  assign bus.overrun  = overrun;

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (bus.pop),
    .din   (shreg),
    .dout  (bus.dout),
    .empty (bus.empty),
    .full  (fifo_full),
    .count (bus.count)
  );

  assign bus.full = fifo_full;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer (honours RX_PARITY_EN)
module tb_uart_rx_deserializer;

  localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
  localparam int STOP_TICKS = 168;
`else
  localparam int STOP_TICKS = 152;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       en = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] baud = 8'd0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = -1;
  int start_cyc = 0;
  logic prev_empty = 1'b1;

  logic [7:0] mq[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;

  uart_rx_deserializer_if #(.DEPTH(DEPTH)) bif();

  uart_rx_deserializer #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .baud (baud),
    .rx   (rx),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_empty && !bif.empty) fall_cyc = cyc;
    prev_empty = bif.empty;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout no_finish_within_limit");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pop();
    bif.pop = 1'b1;
    @(posedge clk);
    #1;
    bif.pop = 1'b0;
  endtask

  task automatic do_clrerr();
    bif.clrerr = 1'b1;
    @(posedge clk);
    #1;
    bif.clrerr = 1'b0;
  endtask

  // One serial character; pop_at/en_off_at are cycle offsets from the start edge (-1 = unused).
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int pop_at, input int en_off_at);
    logic [10:0] bits;
    int nb;
    int per;
    int n;
    per = 16 * (int'(baud) + 1);
`ifdef RX_PARITY_EN
    bits = {stopb, ^d, d, 1'b0};
    nb = 11;
`else
    bits = {1'b1, stopb, d, 1'b0};
    nb = 10;
`endif
    n = 0;
    start_cyc = cyc;
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      for (int c = 0; c < per; c++) begin
        @(posedge clk);
        #1;
        n++;
        bif.pop = (n == pop_at - 1);
        if (n == en_off_at) en = 1'b0;
      end
    end
    rx = 1'b1;
    bif.pop = 1'b0;
    en = 1'b1;
    idle(20 * (int'(baud) + 1));
  endtask

  // Reference model: a received character either errors, lands in the queue, or overruns it.
  task automatic model_frame(input logic [7:0] d, input logic stopb, input bit pop_same);
    if (pop_same && mq.size() > 0) void'(mq.pop_front());
    if (!stopb) exp_fe = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(d);
    else exp_ov = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bif.dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", bif.dout); end
    checks++; if (bif.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bif.empty); end
    checks++; if (bif.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bif.full); end
    checks++; if (bif.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bif.count); end
    checks++; if (bif.frameerr !== 1'b0) begin failures++; $display("FAIL reset_frameerr got=%b exp=0", bif.frameerr); end
    checks++; if (bif.overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", bif.overrun); end
    checks++; if (bif.parityerr !== 1'b0) begin failures++; $display("FAIL reset_parityerr got=%b exp=0", bif.parityerr); end
    nrst = 1'b1;
    idle(2);
    en = 1'b1;
    idle(4);
  endtask

  task automatic test_first_byte();
    int lat;
    baud = 8'd0;
    idle(2);
    fall_cyc = -1;
    send_frame(8'hA5, 1'b1, -1, -1);
    model_frame(8'hA5, 1'b1, 1'b0);
    lat = (fall_cyc < 0) ? -1 : fall_cyc - start_cyc;
    checks++; if (lat != 3 + STOP_TICKS) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", lat, 3 + STOP_TICKS); end
    checks++; if (bif.dout !== 8'hA5) begin failures++; $display("FAIL first_dout got=%h exp=a5", bif.dout); end
    checks++; if (bif.count !== 3'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", bif.count); end
    do_pop();
    void'(mq.pop_front());
    checks++; if (bif.empty !== 1'b1) begin failures++; $display("FAIL first_pop_empty got=%b exp=1", bif.empty); end
    checks++; if (bif.dout !== 8'h00) begin failures++; $display("FAIL first_pop_dout got=%h exp=00", bif.dout); end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    baud = 8'd3;
    idle(2);
    rx = 1'b0;
    idle(int'(baud) + 1);
    rx = 1'b1;
    idle(30 * (int'(baud) + 1));
    checks++; if (bif.count !== 3'(mq.size())) begin failures++; $display("FAIL glitch_count got=%0d exp=%0d", bif.count, mq.size()); end
    checks++; if (bif.frameerr !== 1'b0 || bif.overrun !== 1'b0) begin failures++; $display("FAIL glitch_flags got=%b%b exp=00", bif.frameerr, bif.overrun); end
    d = 8'($urandom);
    send_frame(d, 1'b1, -1, -1);
    model_frame(d, 1'b1, 1'b0);
    checks++; if (bif.dout !== d) begin failures++; $display("FAIL glitch_recover_dout got=%h exp=%h", bif.dout, d); end
    do_pop();
    void'(mq.pop_front());
  endtask

  task automatic test_frame_error();
    baud = 8'd0;
    idle(2);
    send_frame(8'h3C, 1'b0, -1, -1);
    model_frame(8'h3C, 1'b0, 1'b0);
    checks++; if (bif.frameerr !== exp_fe) begin failures++; $display("FAIL frameerr_set got=%b exp=%b", bif.frameerr, exp_fe); end
    checks++; if (bif.count !== 3'(mq.size())) begin failures++; $display("FAIL frameerr_count got=%0d exp=%0d", bif.count, mq.size()); end
    do_clrerr();
    exp_fe = 1'b0;
    checks++; if (bif.frameerr !== exp_fe) begin failures++; $display("FAIL frameerr_clear got=%b exp=%b", bif.frameerr, exp_fe); end
  endtask

  task automatic test_overrun();
    baud = 8'd3;
    idle(2);
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, -1, -1);
      model_frame(8'(i), 1'b1, 1'b0);
    end
    checks++; if (bif.count !== 3'(mq.size())) begin failures++; $display("FAIL overrun_count got=%0d exp=%0d", bif.count, mq.size()); end
    checks++; if (bif.full !== 1'b1) begin failures++; $display("FAIL overrun_full got=%b exp=1", bif.full); end
    checks++; if (bif.overrun !== exp_ov) begin failures++; $display("FAIL overrun_flag got=%b exp=%b", bif.overrun, exp_ov); end
    while (mq.size() > 0) begin
      checks++; if (bif.dout !== mq[0]) begin failures++; $display("FAIL overrun_head got=%h exp=%h", bif.dout, mq[0]); end
      do_pop();
      void'(mq.pop_front());
    end
    checks++; if (bif.empty !== 1'b1) begin failures++; $display("FAIL overrun_drained got=%b exp=1", bif.empty); end
    do_clrerr();
    exp_ov = 1'b0;
    checks++; if (bif.overrun !== exp_ov) begin failures++; $display("FAIL overrun_clear got=%b exp=%b", bif.overrun, exp_ov); end
  endtask

  task automatic test_pop_at_push();
    logic [7:0] d;
    baud = 8'($urandom_range(0, 3));
    idle(2);
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, -1, -1);
      model_frame(d, 1'b1, 1'b0);
    end
    checks++; if (bif.full !== 1'b1) begin failures++; $display("FAIL poppush_prefull got=%b exp=1", bif.full); end
    d = 8'($urandom);
    send_frame(d, 1'b1, 3 + STOP_TICKS * (int'(baud) + 1), -1);
    model_frame(d, 1'b1, 1'b1);
    checks++; if (bif.overrun !== exp_ov) begin failures++; $display("FAIL poppush_overrun got=%b exp=%b", bif.overrun, exp_ov); end
    checks++; if (bif.count !== 3'(mq.size())) begin failures++; $display("FAIL poppush_count got=%0d exp=%0d", bif.count, mq.size()); end
    while (mq.size() > 0) begin
      checks++; if (bif.dout !== mq[0]) begin failures++; $display("FAIL poppush_head got=%h exp=%h", bif.dout, mq[0]); end
      do_pop();
      void'(mq.pop_front());
    end
  endtask

  task automatic test_en_drop();
    logic [7:0] d;
    baud = 8'($urandom_range(0, 2));
    idle(2);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, -1, -1);
      model_frame(d, 1'b1, 1'b0);
    end
    send_frame(8'($urandom), 1'b1, -1, 3 + 40 * (int'(baud) + 1));
    checks++; if (bif.count !== 3'(mq.size())) begin failures++; $display("FAIL endrop_count got=%0d exp=%0d", bif.count, mq.size()); end
    d = 8'($urandom);
    send_frame(d, 1'b1, -1, -1);
    model_frame(d, 1'b1, 1'b0);
    checks++; if (bif.frameerr !== exp_fe) begin failures++; $display("FAIL endrop_frameerr got=%b exp=%b", bif.frameerr, exp_fe); end
    while (mq.size() > 0) begin
      checks++; if (bif.dout !== mq[0]) begin failures++; $display("FAIL endrop_head got=%h exp=%h", bif.dout, mq[0]); end
      do_pop();
      void'(mq.pop_front());
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       sb;
    int         np;
    for (int f = 0; f < 8; f++) begin
      baud = 8'($urandom_range(0, 3));
      idle(2);
      d  = 8'($urandom);
      sb = ($urandom_range(0, 5) != 0);
      send_frame(d, sb, -1, -1);
      model_frame(d, sb, 1'b0);
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        if (mq.size() > 0) begin
          checks++; if (bif.dout !== mq[0]) begin failures++; $display("FAIL random_head got=%h exp=%h", bif.dout, mq[0]); end
          void'(mq.pop_front());
        end
        do_pop();
      end
    end
    checks++; if (bif.count !== 3'(mq.size())) begin failures++; $display("FAIL random_count got=%0d exp=%0d", bif.count, mq.size()); end
    checks++; if (bif.frameerr !== exp_fe) begin failures++; $display("FAIL random_frameerr got=%b exp=%b", bif.frameerr, exp_fe); end
    checks++; if (bif.overrun !== exp_ov) begin failures++; $display("FAIL random_overrun got=%b exp=%b", bif.overrun, exp_ov); end
    while (mq.size() > 0) begin
      checks++; if (bif.dout !== mq[0]) begin failures++; $display("FAIL random_drain got=%h exp=%h", bif.dout, mq[0]); end
      do_pop();
      void'(mq.pop_front());
    end
    do_clrerr();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    checks++; if (bif.frameerr !== 1'b0 || bif.overrun !== 1'b0) begin failures++; $display("FAIL random_clear got=%b%b exp=00", bif.frameerr, bif.overrun); end
  endtask

  initial begin
    bif.pop = 1'b0;
    bif.clrerr = 1'b0;
    test_reset();
    test_first_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_pop_at_push();
    test_en_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
